// File: rtl/seg_disp_pkg.sv
// Shared constants for the six-digit 7-segment scan driver.
// Segment codes are ordered {g,f,e,d,c,b,a}, active-high.
package seg_disp_pkg;

  localparam int NUM_DIG = 6;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // All digit enables deasserted (enables are active-low).
  localparam logic [NUM_DIG-1:0] ENB_OFF = 6'b111111;

endpackage

// File: rtl/seg_scan_disp_fnd_dec.sv
// Combinational hex nibble to 7-segment decoder ({g,f,e,d,c,b,a}, active-high).
module fnd_dec
  import seg_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_disp.sv
// Six-digit multiplexed 7-segment scan driver with double-buffered input.
// Define SEG_LZB_EN to enable leading-zero blanking on digits 1..5.
module seg_scan_disp
  import seg_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [23:0] i_digits,
  input  logic [5:0]  i_dp,
  output logic [5:0]  o_seg_enb,
  output logic [6:0]  o_seg,
  output logic        o_seg_dp,
  output logic        o_frame
);

  localparam int         DW       = $clog2(SCAN_DIV);
  localparam logic [2:0] IDX_LAST = 3'(NUM_DIG - 1);

  logic [DW-1:0] div_cnt;
  logic [2:0]    idx;
  logic [23:0]   shadow_dig, disp_dig;
  logic [5:0]    shadow_dp, disp_dp;
  logic          pending;

  logic tick, frame_bnd, dead;
  logic [3:0]         cur_nib;
  logic               cur_dp, cur_blank;
  logic [NUM_DIG-1:0] lz_mask;
  logic               lz_zero;
  logic [6:0]         dec_seg;

  assign tick      = (div_cnt == DW'(SCAN_DIV - 1));
  assign frame_bnd = tick && (idx == IDX_LAST);
  assign dead      = (div_cnt < DW'(DEAD_CYC));

  // Scan position and the shadow/display double buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      idx        <= '0;
      shadow_dig <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      disp_dig   <= '0;
      disp_dp    <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
      if (i_valid) begin
        shadow_dig <= i_digits;
        shadow_dp  <= i_dp;
      end
      // A strobe on the boundary bypasses the shadow so it is never lost.
      if (frame_bnd) begin
        if (i_valid) begin
          disp_dig <= i_digits;
          disp_dp  <= i_dp;
          pending  <= 1'b0;
        end else if (pending) begin
          disp_dig <= shadow_dig;
          disp_dp  <= shadow_dp;
          pending  <= 1'b0;
        end
      end else if (i_valid) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    lz_mask = '0;
    lz_zero = 1'b1;
`ifdef SEG_LZB_EN
    for (int n = NUM_DIG - 1; n >= 1; n--) begin
      lz_zero    = lz_zero && (disp_dig[n*4 +: 4] == 4'h0);
      lz_mask[n] = lz_zero;
    end
`endif
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int n = 0; n < NUM_DIG; n++) begin
      if (idx == 3'(n)) begin
        cur_nib   = disp_dig[n*4 +: 4];
        cur_dp    = disp_dp[n];
        cur_blank = lz_mask[n];
      end
    end
  end

  fnd_dec u_dec (
    .nib (cur_nib),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_seg_enb <= ENB_OFF;
      o_seg     <= SEG_BLANK;
      o_seg_dp  <= 1'b0;
      o_frame   <= 1'b0;
    end else begin
      o_frame <= frame_bnd;
      if (dead) begin
        o_seg_enb <= ENB_OFF;
        o_seg     <= SEG_BLANK;
        o_seg_dp  <= 1'b0;
      end else begin
        o_seg_enb <= ~(6'b000001 << idx);
        o_seg     <= cur_blank ? SEG_BLANK : dec_seg;
        o_seg_dp  <= cur_dp;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_disp.sv
// Scoreboard bench for seg_scan_disp (SCAN_DIV=4, DEAD_CYC=1); honours SEG_LZB_EN.
module tb_seg_scan_disp;

  localparam int SD = 4;
  localparam int DC = 1;
  localparam int FR = 6 * SD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [23:0] i_digits;
  logic [5:0]  i_dp;
  logic [5:0]  o_seg_enb;
  logic [6:0]  o_seg;
  logic        o_seg_dp;
  logic        o_frame;

  seg_scan_disp #(.SCAN_DIV(SD), .DEAD_CYC(DC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .i_digits  (i_digits),
    .i_dp      (i_dp),
    .o_seg_enb (o_seg_enb),
    .o_seg     (o_seg),
    .o_seg_dp  (o_seg_dp),
    .o_frame   (o_frame)
  );

  always #5 clk = ~clk;

  // {o_frame, o_seg_enb, o_seg, o_seg_dp}
  logic [14:0] exp_q[$];
  int          st_k[$];
  logic [29:0] st_d[$];
  int          k;
  int          mk;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;  default: return 7'b1110001;
    endcase
  endfunction

  // Output seen after clock edge kk: the display holds the last strobe taken
  // before the start of the current frame.
  function automatic logic [14:0] model(input int kk);
    int          dv, ix, limit;
    logic [29:0] cur;
    logic [23:0] dg;
    logic [5:0]  enb;
    logic [6:0]  sg;
    logic        fr;
    dv    = kk % SD;
    ix    = (kk / SD) % 6;
    limit = FR * (kk / FR);
    cur   = '0;
    for (int i = 0; i < st_k.size(); i++)
      if (st_k[i] < limit) cur = st_d[i];
    dg = cur[29:6];
    fr = (dv == SD - 1) && (ix == 5);
    if (dv < DC) return {fr, 6'b111111, 7'b0, 1'b0};
    enb = 6'b000001 << ix;
    sg  = ref_seg(dg[ix*4 +: 4]);
`ifdef SEG_LZB_EN
    if (ix > 0 && (dg >> (4 * ix)) == 24'h0) sg = 7'b0;
`endif
    return {fr, ~enb, sg, cur[ix]};
  endfunction

  task automatic step(input logic v, input logic [23:0] d, input logic [5:0] p);
    @(negedge clk);
    i_valid  = v;
    i_digits = d;
    i_dp     = p;
    if (v) begin
      st_k.push_back(k);
      st_d.push_back({d, p});
    end
    exp_q.push_back(model(k));
    k++;
  endtask

  task automatic idle_to(input int kend);
    while (k < kend) step(1'b0, 24'($urandom), 6'($urandom));
  endtask

  task automatic check_reset(input string name);
    n_vec++;
    if ({o_frame, o_seg_enb, o_seg, o_seg_dp} !== {1'b0, 6'b111111, 7'b0, 1'b0}) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, {o_frame, o_seg_enb, o_seg, o_seg_dp},
               {1'b0, 6'b111111, 7'b0, 1'b0});
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    k = 0;
    mk = 0;
    st_k.delete();
    st_d.delete();
  endtask

  // Monitor: every cycle after the edge, one expected word is consumed.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [14:0] e;
        e = exp_q.pop_front();
        n_vec++;
        if ({o_frame, o_seg_enb, o_seg, o_seg_dp} !== e) begin
          n_err++;
          $display("FAIL out k=%0d got=%h exp=%h", mk, {o_frame, o_seg_enb, o_seg, o_seg_dp}, e);
        end
        mk++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] msk;
    rst_n = 1'b0; i_valid = 1'b0; i_digits = '0; i_dp = '0;
    k = 0; mk = 0;
    repeat (3) begin
      @(posedge clk);
      #1 check_reset("reset_hold");
    end
    release_reset();

    idle_to(50);
    step(1'b1, 24'h123456, 6'b000100);
    idle_to(143);
    step(1'b1, 24'hFEDCBA, 6'b000000);
    idle_to(200);
    step(1'b1, 24'h000001, 6'b000000);
    idle_to(210);
    step(1'b1, 24'h000009, 6'b000000);
    idle_to(250);
    step(1'b1, 24'h000042, 6'b100001);
    idle_to(300);
    step(1'b1, 24'h000000, 6'b000000);
    idle_to(350);

    for (int i = 0; i < 600; i++) begin
      msk = 24'hFFFFFF >> (4 * (6 - $urandom_range(0, 6)));
      step($urandom_range(0, 15) == 0, 24'($urandom) & msk, 6'($urandom));
    end
    idle_to(k + 2 - (k % SD) + SD);

    // Reset mid-slot: outputs must return to idle without a clock edge.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset("reset_async");
    repeat (3) begin
      @(posedge clk);
      #1 check_reset("reset_hold2");
    end
    release_reset();
    for (int i = 0; i < 100; i++)
      step($urandom_range(0, 7) == 0, 24'($urandom), 6'($urandom));

    @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
